// File: rtl/ysyx_25040101_exu_result_stage.sv
// Execute-stage back end: resolves SLT/SLTU/branch/jump results from the ALU
// and carries them through a 2-entry skid buffer toward LSU/WBU, with a PC redirect pulse to the IFU.
module ysyx_25040101_exu_result_stage #(
    parameter int unsigned RD_W = 5,
    parameter int unsigned PC_W = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     alu_result_i,
    input  logic            borrow_i,
    input  logic            sub_overflow_i,
    input  logic [1:0]      res_sel_i,
    input  logic [2:0]      br_op_i,
    input  logic            is_branch_i,
    input  logic            is_jal_i,
    input  logic            is_jalr_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] imm_i,
    input  logic [RD_W-1:0] rd_i,
    input  logic            rd_wen_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     wb_data_o,
    output logic [RD_W-1:0] rd_o,
    output logic            rd_wen_o,
    output logic            redirect_valid_o,
    output logic [PC_W-1:0] redirect_pc_o,
    output logic            misalign_o
);

    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [RD_W-1:0] rd;
        logic            wen;
    } entry_t;

    entry_t          main_q, main_d, skid_q, skid_d, new_entry;
    logic            main_valid_q, main_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            redir_valid_q, redir_valid_d;
    logic [PC_W-1:0] redir_pc_q, redir_pc_d;
    logic            misalign_q, misalign_d;

    logic            eq, lt, ltu, br_cond, is_cond, taken;
    logic            in_fire, out_fire;
    logic [PC_W-1:0] target;

    // Decode the incoming ALU entry: result select, branch outcome, target
    always_comb begin
        eq      = (alu_result_i == '0);
        lt      = alu_result_i[31] ^ sub_overflow_i;
        ltu     = borrow_i;
        br_cond = 1'b0;
        case (br_op_i)
            3'b000:  br_cond = eq;
            3'b001:  br_cond = ~eq;
            3'b100:  br_cond = lt;
            3'b101:  br_cond = ~lt;
            3'b110:  br_cond = ltu;
            3'b111:  br_cond = ~ltu;
            default: br_cond = 1'b0;
        endcase
        // JALR beats JAL beats branch when several flags are raised
        is_cond = is_branch_i & ~is_jal_i & ~is_jalr_i;
        taken   = is_jalr_i | is_jal_i | (is_cond & br_cond);
        target  = is_jalr_i ? PC_W'(alu_result_i & ~32'h1) : PC_W'(pc_i + imm_i);

        new_entry.data = alu_result_i;
        case (res_sel_i)
            2'd1:    new_entry.data = {31'b0, lt};
            2'd2:    new_entry.data = {31'b0, ltu};
            2'd3:    new_entry.data = XLEN'(pc_i + PC_W'(4));
            default: new_entry.data = alu_result_i;
        endcase
        new_entry.rd  = rd_i;
        new_entry.wen = rd_wen_i & ~is_cond;
    end

    assign in_fire  = in_valid_i & in_ready_q & ~flush_i;
    assign out_fire = main_valid_q & out_ready_i;

    // Skid buffer next state; in_fire with a draining, full skid cannot happen
    always_comb begin
        main_d        = main_q;
        skid_d        = skid_q;
        main_valid_d  = main_valid_q;
        skid_valid_d  = skid_valid_q;
        redir_valid_d = in_fire & taken;
        redir_pc_d    = redir_pc_q;
        misalign_d    = 1'b0;

        if (in_fire && taken) begin
            redir_pc_d = target;
            misalign_d = (target[1:0] != 2'b00);
        end

        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_fire) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_d = new_entry;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            if (!main_valid_q) begin
                main_d       = new_entry;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = new_entry;
                skid_valid_d = 1'b1;
            end
        end
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            main_q        <= '0;
            skid_q        <= '0;
            main_valid_q  <= 1'b0;
            skid_valid_q  <= 1'b0;
            in_ready_q    <= 1'b1;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            misalign_q    <= 1'b0;
        end else begin
            main_q        <= main_d;
            skid_q        <= skid_d;
            main_valid_q  <= main_valid_d;
            skid_valid_q  <= skid_valid_d;
            in_ready_q    <= in_ready_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            misalign_q    <= misalign_d;
        end
    end

    assign in_ready_o       = in_ready_q;
    assign out_valid_o      = main_valid_q;
    assign wb_data_o        = main_q.data;
    assign rd_o             = main_q.rd;
    assign rd_wen_o         = main_q.wen;
    assign redirect_valid_o = redir_valid_q;
    assign redirect_pc_o    = redir_pc_q;
    assign misalign_o       = misalign_q;

endmodule

// File: tb/tb_ysyx_25040101_exu_result_stage.sv
// Directed bench for the execute result stage: vector table streamed at full
// rate, plus hand sequences for backpressure, flush and mid-stream reset.
module tb_ysyx_25040101_exu_result_stage;

    logic        clock = 1'b0;
    logic        reset, flush_i, in_valid_i, in_ready_o;
    logic [31:0] alu_result_i;
    logic        borrow_i, sub_overflow_i;
    logic [1:0]  res_sel_i;
    logic [2:0]  br_op_i;
    logic        is_branch_i, is_jal_i, is_jalr_i;
    logic [31:0] pc_i, imm_i;
    logic [4:0]  rd_i;
    logic        rd_wen_i;
    logic        out_valid_o, out_ready_i;
    logic [31:0] wb_data_o;
    logic [4:0]  rd_o;
    logic        rd_wen_o, redirect_valid_o, misalign_o;
    logic [31:0] redirect_pc_o;

    int n_cmp  = 0;
    int n_fail = 0;

    ysyx_25040101_exu_result_stage #(.RD_W(5), .PC_W(32)) dut (
        .clock(clock), .reset(reset), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .alu_result_i(alu_result_i), .borrow_i(borrow_i), .sub_overflow_i(sub_overflow_i),
        .res_sel_i(res_sel_i), .br_op_i(br_op_i),
        .is_branch_i(is_branch_i), .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i),
        .pc_i(pc_i), .imm_i(imm_i), .rd_i(rd_i), .rd_wen_i(rd_wen_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .wb_data_o(wb_data_o), .rd_o(rd_o), .rd_wen_o(rd_wen_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .misalign_o(misalign_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  res_sel;
        logic [2:0]  br_op;
        logic        is_br, is_jal, is_jalr;
        logic [31:0] alu;
        logic        borrow, ovf;
        logic [31:0] pc, imm;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] e_wb;
        logic        e_wen, e_rv;
        logic [31:0] e_rpc;
        logic        e_mis;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        in_valid_i = 0; flush_i = 0; alu_result_i = 0; borrow_i = 0; sub_overflow_i = 0;
        res_sel_i = 0; br_op_i = 0; is_branch_i = 0; is_jal_i = 0; is_jalr_i = 0;
        pc_i = 0; imm_i = 0; rd_i = 0; rd_wen_i = 0;
    endtask

    task automatic apply(input vec_t v);
        in_valid_i = 1; res_sel_i = v.res_sel; br_op_i = v.br_op;
        is_branch_i = v.is_br; is_jal_i = v.is_jal; is_jalr_i = v.is_jalr;
        alu_result_i = v.alu; borrow_i = v.borrow; sub_overflow_i = v.ovf;
        pc_i = v.pc; imm_i = v.imm; rd_i = v.rd; rd_wen_i = v.wen;
    endtask

    task automatic put_alu(input logic [31:0] val, input logic [4:0] rd);
        idle_inputs();
        in_valid_i = 1; alu_result_i = val; rd_i = rd; rd_wen_i = 1;
    endtask

    function automatic vec_t mk(input logic [1:0] rs, input logic [2:0] bo, input logic b,
                                input logic j, input logic jr, input logic [31:0] alu,
                                input logic bw, input logic ov, input logic [31:0] pc,
                                input logic [31:0] imm, input logic [4:0] rd, input logic wen,
                                input logic [31:0] ewb, input logic ewen, input logic erv,
                                input logic [31:0] erpc, input logic emis);
        vec_t v;
        v.res_sel = rs; v.br_op = bo; v.is_br = b; v.is_jal = j; v.is_jalr = jr;
        v.alu = alu; v.borrow = bw; v.ovf = ov; v.pc = pc; v.imm = imm; v.rd = rd; v.wen = wen;
        v.e_wb = ewb; v.e_wen = ewen; v.e_rv = erv; v.e_rpc = erpc; v.e_mis = emis;
        return v;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready_o), 32'd1);
        check({tag, "_redirect_valid"}, 32'(redirect_valid_o), 32'd0);
        check({tag, "_misalign"}, 32'(misalign_o), 32'd0);
        check({tag, "_wb_data"}, wb_data_o, 32'd0);
        check({tag, "_rd"}, 32'(rd_o), 32'd0);
        check({tag, "_rd_wen"}, 32'(rd_wen_o), 32'd0);
        check({tag, "_redirect_pc"}, redirect_pc_o, 32'd0);
    endtask

    initial begin
        //           sel  op     br jal jr  alu           bw ov pc            imm           rd wen  wb            wen rv rpc           mis
        vecs[0]  = mk(2'd0, 3'b000, 0, 0, 0, 32'h12345678, 0, 0, 32'h0,        32'h0,        5, 1, 32'h12345678, 1, 0, 32'h0,        0);
        vecs[1]  = mk(2'd1, 3'b000, 0, 0, 0, 32'hFFFFFFFE, 0, 0, 32'h0,        32'h0,        6, 1, 32'h1,        1, 0, 32'h0,        0);
        vecs[2]  = mk(2'd2, 3'b000, 0, 0, 0, 32'hFFFFFFFE, 0, 0, 32'h0,        32'h0,        7, 1, 32'h0,        1, 0, 32'h0,        0);
        vecs[3]  = mk(2'd1, 3'b000, 0, 0, 0, 32'h7FFFFFFF, 0, 1, 32'h0,        32'h0,        8, 1, 32'h1,        1, 0, 32'h0,        0);
        vecs[4]  = mk(2'd0, 3'b000, 1, 0, 0, 32'h0,        0, 0, 32'h80000010, 32'hFFFFFFF0, 9, 1, 32'h0,        0, 1, 32'h80000000, 0);
        vecs[5]  = mk(2'd0, 3'b001, 1, 0, 0, 32'h0,        0, 0, 32'h80000010, 32'hFFFFFFF0, 9, 1, 32'h0,        0, 0, 32'h0,        0);
        vecs[6]  = mk(2'd3, 3'b000, 0, 0, 1, 32'h80000103, 0, 0, 32'h80000020, 32'h0,        1, 1, 32'h80000024, 1, 1, 32'h80000102, 1);
        vecs[7]  = mk(2'd3, 3'b000, 0, 1, 0, 32'h0,        0, 0, 32'h80000000, 32'h10,       1, 1, 32'h80000004, 1, 1, 32'h80000010, 0);
        vecs[8]  = mk(2'd0, 3'b100, 1, 0, 0, 32'h80000000, 0, 0, 32'h100,      32'h8,        2, 1, 32'h80000000, 0, 1, 32'h108,      0);
        vecs[9]  = mk(2'd0, 3'b111, 1, 0, 0, 32'h5,        1, 0, 32'h100,      32'h8,        2, 1, 32'h5,        0, 0, 32'h0,        0);
        vecs[10] = mk(2'd0, 3'b110, 1, 0, 0, 32'h5,        1, 0, 32'hFFFFFFFC, 32'h8,        2, 1, 32'h5,        0, 1, 32'h4,        0);
        vecs[11] = mk(2'd0, 3'b010, 1, 0, 0, 32'h0,        0, 0, 32'h100,      32'h8,        2, 1, 32'h0,        0, 0, 32'h0,        0);
        vecs[12] = mk(2'd3, 3'b000, 1, 1, 1, 32'h2000,     0, 0, 32'h100,      32'h40,       3, 1, 32'h104,      1, 1, 32'h2000,     0);
        vecs[13] = mk(2'd3, 3'b000, 0, 0, 0, 32'h0,        0, 0, 32'hFFFFFFFC, 32'h0,        4, 1, 32'h0,        1, 0, 32'h0,        0);
        vecs[14] = mk(2'd0, 3'b101, 1, 0, 0, 32'h5,        0, 0, 32'h200,      32'h2,        4, 1, 32'h5,        0, 1, 32'h202,      1);

        idle_inputs();
        reset = 1; out_ready_i = 1;
        repeat (2) @(negedge clock);
        reset = 0;
        @(negedge clock);
        check_reset_state("reset");

        // Full-rate stream: each vector's result appears one cycle after it is driven
        for (int i = 0; i < 15; i++) begin
            apply(vecs[i]);
            @(negedge clock);
            check($sformatf("v%0d_out_valid", i), 32'(out_valid_o), 32'd1);
            check($sformatf("v%0d_in_ready", i), 32'(in_ready_o), 32'd1);
            check($sformatf("v%0d_wb_data", i), wb_data_o, vecs[i].e_wb);
            check($sformatf("v%0d_rd", i), 32'(rd_o), 32'(vecs[i].rd));
            check($sformatf("v%0d_rd_wen", i), 32'(rd_wen_o), 32'(vecs[i].e_wen));
            check($sformatf("v%0d_redirect_valid", i), 32'(redirect_valid_o), 32'(vecs[i].e_rv));
            check($sformatf("v%0d_misalign", i), 32'(misalign_o), 32'(vecs[i].e_mis));
            if (vecs[i].e_rv)
                check($sformatf("v%0d_redirect_pc", i), redirect_pc_o, vecs[i].e_rpc);
        end
        idle_inputs();
        @(negedge clock);
        check("drain_out_valid", 32'(out_valid_o), 32'd0);
        check("pulse_one_cycle", 32'(redirect_valid_o), 32'd0);

        // Backpressure: A, B held, C waits for space
        out_ready_i = 0;
        put_alu(32'hA, 5'd10);
        @(negedge clock);
        check("bp_ready_after_a", 32'(in_ready_o), 32'd1);
        put_alu(32'hB, 5'd11);
        @(negedge clock);
        check("bp_ready_after_b", 32'(in_ready_o), 32'd0);
        put_alu(32'hC, 5'd12);
        repeat (3) begin
            @(negedge clock);
            check("bp_hold_valid", 32'(out_valid_o), 32'd1);
            check("bp_hold_data", wb_data_o, 32'hA);
            check("bp_hold_ready", 32'(in_ready_o), 32'd0);
        end
        out_ready_i = 1;
        @(negedge clock);
        check("bp_second", wb_data_o, 32'hB);
        check("bp_second_rd", 32'(rd_o), 32'd11);
        check("bp_ready_release", 32'(in_ready_o), 32'd1);
        @(negedge clock);
        check("bp_third", wb_data_o, 32'hC);
        check("bp_third_valid", 32'(out_valid_o), 32'd1);
        idle_inputs();
        @(negedge clock);
        check("bp_empty", 32'(out_valid_o), 32'd0);

        // Flush with both entries full; the input offered alongside is dropped
        out_ready_i = 0;
        put_alu(32'h11, 5'd1);
        @(negedge clock);
        put_alu(32'h22, 5'd2);
        @(negedge clock);
        check("fl_full_ready", 32'(in_ready_o), 32'd0);
        put_alu(32'h33, 5'd3);
        flush_i = 1;
        @(negedge clock);
        check("fl_out_valid", 32'(out_valid_o), 32'd0);
        check("fl_in_ready", 32'(in_ready_o), 32'd1);
        idle_inputs();
        @(negedge clock);
        check("fl_suppressed", 32'(out_valid_o), 32'd0);

        // Reset while full and a redirect is pending
        put_alu(32'h44, 5'd4);
        @(negedge clock);
        idle_inputs();
        in_valid_i = 1; is_jal_i = 1; res_sel_i = 2'd3; pc_i = 32'h10; imm_i = 32'h6; rd_i = 5'd3; rd_wen_i = 1;
        @(negedge clock);
        check("rs_pre_redirect", 32'(redirect_valid_o), 32'd1);
        check("rs_pre_misalign", 32'(misalign_o), 32'd1);
        idle_inputs();
        reset = 1;
        @(negedge clock);
        reset = 0;
        check_reset_state("midreset");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/ysyx_25040101_exu_result_stage.md
Name: ysyx_25040101_exu_result_stage

Overview:
Execute-stage back end sitting directly downstream of ysyx_25040101_alu. It consumes alu_result_o, borrow_o and sub_overflow_o, then resolves SLT/SLTU, branch and jump outcomes. Results are registered into a 2-entry skid buffer with a valid/ready handshake toward the LSU/WBU, and the stage pulses a PC redirect to the IFU. Full throughput: one instruction per cycle when downstream is ready.

Parameters:
RD_W, 5, destination register index width
PC_W, 32, PC / address width (fixed 32 in this core; parameter exists for lint only)

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
flush_i  in  1  drop all buffered entries
in_valid_i  in  1  upstream (ALU-side) entry valid
in_ready_o  out  1  stage can accept an entry
alu_result_i  in  32  ALU result
borrow_i  in  1  ALU borrow (a <u b on subtract)
sub_overflow_i  in  1  ALU signed subtract overflow
res_sel_i  in  2  0=ALU, 1=SLT, 2=SLTU, 3=LINK (pc+4)
br_op_i  in  3  branch funct3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU)
is_branch_i  in  1  conditional branch
is_jal_i  in  1  JAL
is_jalr_i  in  1  JALR
pc_i  in  32  instruction PC
imm_i  in  32  sign-extended immediate
rd_i  in  RD_W  destination index
rd_wen_i  in  1  register write enable
out_valid_o  out  1  result entry valid
out_ready_i  in  1  downstream accepts
wb_data_o  out  32  writeback / memory address value
rd_o  out  RD_W  destination index
rd_wen_o  out  1  write enable
redirect_valid_o  out  1  one-cycle PC redirect pulse
redirect_pc_o  out  32  redirect target
misalign_o  out  1  redirect target[1:0] != 0 (with redirect_valid_o)

Behaviour:
- Handshake: in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- in_ready_o = ~skid_valid (registered state only; no combinational path from out_ready_i).
- Storage: main entry (drives outputs) + skid entry.
  - in_fire with main empty, or main draining this cycle (out_fire) and skid empty -> load main.
  - in_fire while main full and not draining -> load skid.
  - out_fire with skid full -> skid moves to main; skid clears.
- Order is strictly FIFO; no entry is dropped or duplicated.
- Result select (computed combinationally at input, stored in the entry):
  - ALU: alu_result_i.
  - SLT: {31'b0, alu_result_i[31] ^ sub_overflow_i}.
  - SLTU: {31'b0, borrow_i}.
  - LINK: pc_i + 4, 32-bit wraparound.
- Branch compare uses ALU subtract flags:
  - eq = (alu_result_i == 0); lt = alu_result_i[31] ^ sub_overflow_i; ltu = borrow_i.
  - BNE/BGE/BGEU are the negations of eq/lt/ltu.
  - An undefined br_op -> not taken.
- Target:
  - JAL or taken branch: pc_i + imm_i.
  - JALR: alu_result_i & ~32'h1.
  - Wraparound is modulo 2^32.
- Redirect:
  - Cycle after in_fire of a taken branch/JAL/JALR: redirect_valid_o = 1 for exactly one cycle, with redirect_pc_o/misalign_o valid.
  - Otherwise redirect_valid_o = 0.
  - Redirect fires at acceptance and does not wait for out_fire.
- Priority: is_jalr_i > is_jal_i > is_branch_i if more than one is asserted.
- Branch entries still pass downstream with rd_wen_o = 0 (rd_wen_i forced low for branches).
- flush_i (same cycle):
  - Clears main and skid valid and suppresses any in_fire that cycle.
  - A redirect already registered still emits the next cycle.
- Reset:
  - out_valid_o = 0, skid empty, in_ready_o = 1 in the first cycle after reset.
  - redirect_valid_o = 0, misalign_o = 0.
  - wb_data_o, rd_o, rd_wen_o, redirect_pc_o = 0.
  - Reset mid-transfer discards all entries.
- Simultaneous in_fire + out_fire with skid full cannot occur, because in_ready_o = 0.
- Data outputs are stable while out_valid_o & ~out_ready_i.

Test Plan:
- Streaming: 8 ALU entries back-to-back with out_ready_i = 1 -> out_valid_o continuous from cycle 1, results in order, in_ready_o never drops.
- Backpressure: out_ready_i = 0 for 4 cycles while feeding 3 entries -> first two are held, in_ready_o = 0 after the 2nd accept; on release, entries emerge in order with no loss.
- SLT/SLTU: a = 0xFFFFFFFF, b = 1, sub (result 0xFFFFFFFE, borrow = 0, ovf = 0) -> SLT gives 1, SLTU gives 0. a = 0x80000000, b = 1 (ovf = 1) -> SLT gives 1.
- Branches: pc = 0x80000010, imm = 0xFFFFFFF0, BEQ with zero result -> redirect pulse one cycle later, redirect_pc_o = 0x80000000, rd_wen_o = 0. BNE with the same inputs -> no pulse.
- JALR: alu_result = 0x80000103, pc = 0x80000020 -> redirect_pc_o = 0x80000102, misalign_o = 1, wb_data_o = 0x80000024.
- Flush/reset: both entries full, assert flush_i -> next cycle out_valid_o = 0, in_ready_o = 1. Assert reset mid-stream -> all outputs return to their reset values.
